// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: op codes and PHT counter helpers.
package branch_resolve_unit_pkg;

  localparam int unsigned BR_OP_WD = 4;

  // Branch/jump operation codes as presented by decode
  typedef enum logic [BR_OP_WD-1:0] {
    BrOpNone = 4'd0,
    BrOpBeq  = 4'd1,
    BrOpBne  = 4'd2,
    BrOpBlt  = 4'd3,
    BrOpBge  = 4'd4,
    BrOpBltu = 4'd5,
    BrOpBgeu = 4'd6,
    BrOpB    = 4'd7,
    BrOpBl   = 4'd8,
    BrOpJirl = 4'd9
  } br_op_e;

  // Counter reset value: weakly not-taken, i.e. just below the taken threshold
  function automatic int unsigned pht_ctr_init(input int unsigned ctr_wd);
    return (32'd1 << (ctr_wd - 1)) - 32'd1;
  endfunction

  // Conditional ops are the only ones that train the direction table
  function automatic logic is_cond_op(input br_op_e op);
    return (op == BrOpBeq) || (op == BrOpBne) || (op == BrOpBlt) ||
           (op == BrOpBge) || (op == BrOpBltu) || (op == BrOpBgeu);
  endfunction

  // Any real control-transfer op (excludes NONE and unused encodings)
  function automatic logic is_branch_op(input br_op_e op);
    return is_cond_op(op) || (op == BrOpB) || (op == BrOpBl) || (op == BrOpJirl);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bru_pht.sv
// bru_pht: pattern history table of saturating direction counters.
// Combinational read port for fetch, single synchronous update port from retire.
// A same-cycle read of the entry being updated returns the pre-update value.
module bru_pht
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned IDX_WD = 6,
  parameter int unsigned CTR_WD = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [IDX_WD-1:0] rd_idx,
  output logic              rd_taken,
  input  logic              upd_en,
  input  logic [IDX_WD-1:0] upd_idx,
  input  logic              upd_taken
);

  localparam int unsigned       Entries = 2 ** IDX_WD;
  localparam logic [CTR_WD-1:0] CtrInit = CTR_WD'(pht_ctr_init(CTR_WD));
  localparam logic [CTR_WD-1:0] CtrMax  = '1;

  logic [CTR_WD-1:0] ctr_q [Entries];
  logic [CTR_WD-1:0] upd_cur;
  logic [CTR_WD-1:0] upd_ctr_d;

  assign upd_cur = ctr_q[upd_idx];

  // Saturating increment/decrement of the entry being trained
  always_comb begin
    upd_ctr_d = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CtrMax) upd_ctr_d = upd_cur + CTR_WD'(1);
    end else begin
      if (upd_cur != '0) upd_ctr_d = upd_cur - CTR_WD'(1);
    end
  end

  // Counter array with async reset to weak not-taken
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= CtrInit;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= upd_ctr_d;
    end
  end

  assign rd_taken = ctr_q[rd_idx][CTR_WD-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered resolve stage for branches/jumps.
// Resolves direction and target from the stage registers, flags mispredicts against the
// fetch-predicted PC, pulses br_cancel on output fire, and trains a PHT read by fetch.
// Optional build macro BRU_STAT_EN adds branch and mispredict statistic counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned DATA_WD    = 32,
  parameter int unsigned PHT_IDX_WD = 6,
  parameter int unsigned CTR_WD     = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BR_OP_WD-1:0] in_br_op,
  input  logic [DATA_WD-1:0] in_pc,
  input  logic [DATA_WD-1:0] in_pred_pc,
  input  logic [DATA_WD-1:0] in_offs,
  input  logic [DATA_WD-1:0] in_src1,
  input  logic [DATA_WD-1:0] in_src2,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_WD-1:0] out_next_pc,
  output logic [DATA_WD-1:0] out_link_pc,
  output logic               br_cancel,
  output logic [DATA_WD-1:0] redirect_pc,
  input  logic [DATA_WD-1:0] lk_pc,
  output logic               lk_taken
`ifdef BRU_STAT_EN
  ,
  output logic [31:0]        stat_br_cnt,
  output logic [31:0]        stat_mispred_cnt
`endif
);

  logic               valid_q;
  br_op_e             op_q;
  logic [DATA_WD-1:0] pc_q;
  logic [DATA_WD-1:0] pred_q;
  logic [DATA_WD-1:0] offs_q;
  logic [DATA_WD-1:0] src1_q;
  logic [DATA_WD-1:0] src2_q;

  logic               accept;
  logic               out_fire;
  logic               taken;
  logic               mispredict;
  logic [DATA_WD-1:0] target;
  logic [DATA_WD-1:0] seq_pc;
  logic [DATA_WD-1:0] next_pc;
  logic               pht_upd_en;

  assign in_ready = ~valid_q | out_ready;
  // A flush in the same cycle discards the incoming request
  assign accept   = in_valid & in_ready & ~flush;
  // A flushed entry never fires, so it neither cancels nor trains
  assign out_fire = valid_q & out_ready & ~flush;

  // Stage valid and payload registers; payload only moves on accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      op_q    <= BrOpNone;
      pc_q    <= '0;
      pred_q  <= '0;
      offs_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
      end
      if (accept) begin
        op_q   <= br_op_e'(in_br_op);
        pc_q   <= in_pc;
        pred_q <= in_pred_pc;
        offs_q <= in_offs;
        src1_q <= in_src1;
        src2_q <= in_src2;
      end
    end
  end

  // Direction and target resolution from the registered operands
  always_comb begin
    taken  = 1'b0;
    target = pc_q + offs_q;
    unique case (op_q)
      BrOpBeq:  taken = (src1_q == src2_q);
      BrOpBne:  taken = (src1_q != src2_q);
      BrOpBlt:  taken = ($signed(src1_q) < $signed(src2_q));
      BrOpBge:  taken = ($signed(src1_q) >= $signed(src2_q));
      BrOpBltu: taken = (src1_q < src2_q);
      BrOpBgeu: taken = (src1_q >= src2_q);
      BrOpB,
      BrOpBl:   taken = 1'b1;
      BrOpJirl: begin
        taken  = 1'b1;
        target = src1_q + offs_q;
      end
      default:  taken = 1'b0;
    endcase
  end

  assign seq_pc     = pc_q + DATA_WD'(4);
  assign next_pc    = taken ? target : seq_pc;
  assign mispredict = (next_pc != pred_q);

  assign out_valid   = valid_q;
  assign out_next_pc = next_pc;
  assign out_link_pc = seq_pc;
  assign redirect_pc = next_pc;
  assign br_cancel   = out_fire & mispredict;

  assign pht_upd_en = out_fire & is_cond_op(op_q);

  bru_pht #(
    .IDX_WD (PHT_IDX_WD),
    .CTR_WD (CTR_WD)
  ) u_pht (
    .clk       (clk),
    .resetn    (resetn),
    .rd_idx    (lk_pc[PHT_IDX_WD+1:2]),
    .rd_taken  (lk_taken),
    .upd_en    (pht_upd_en),
    .upd_idx   (pc_q[PHT_IDX_WD+1:2]),
    .upd_taken (taken)
  );

  // PC bits outside the table index are intentionally ignored
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[DATA_WD-1:PHT_IDX_WD+2], lk_pc[1:0]};

`ifdef BRU_STAT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Saturating statistic counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (out_fire && is_branch_op(op_q) && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (br_cancel && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign stat_br_cnt      = br_cnt_q;
  assign stat_mispred_cnt = mispred_cnt_q;
`endif

endmodule
